// File: rtl/lsu_mem_port.sv
// lsu_mem_port
// Load/store unit sitting between the MEM pipeline stage and a simple
// request/acknowledge data-memory bus. It checks size/alignment of each
// request, builds byte strobes and lane-replicated store data, holds the
// pipeline while the bus transfer is in flight, and returns sign- or
// zero-extended load data.
//
// Parameters
//   ADDR_W     byte address width (data path is fixed at 32 bits)
//   BIG_ENDIAN 0 = little-endian lane mapping, 1 = big-endian lane mapping
//   TIMEOUT    WAIT cycles allowed without mem_ack before bus_err (0 = never)
//
// Ports
//   clk, rst                         clock, synchronous active-high reset
//   req_valid/we/size/signed/addr/wdata  MEM-stage request
//   stall                            hold the pipeline
//   rdata, rdata_valid               extended load data, 1-cycle completion pulse
//   adel, ades, bus_err, bad_addr    error pulses and the faulting address
//   mem_en, mem_wen, mem_addr, mem_wdata  bus request side
//   mem_rdata, mem_ack               bus response side
module lsu_mem_port #(
  parameter int ADDR_W     = 32,
  parameter bit BIG_ENDIAN = 1'b0,
  parameter int TIMEOUT    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic [31:0]       rdata,
  output logic              rdata_valid,
  output logic              adel,
  output logic              ades,
  output logic              bus_err,
  output logic [ADDR_W-1:0] bad_addr,
  output logic              mem_en,
  output logic [3:0]        mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } lsuState;

  lsuState stateReg, stateNext;

  // Registered request context
  logic [ADDR_W-1:0] addrReg;
  logic [1:0]        sizeReg;
  logic              signedReg;
  logic              weReg;
  logic [3:0]        wenReg;
  logic [31:0]       wdataReg;
  logic [CNT_W-1:0]  waitCnt;

  // Registered outputs
  logic [31:0]       rdataReg;
  logic              adelReg;
  logic              adesReg;
  logic              busErrReg;
  logic [ADDR_W-1:0] badAddrReg;

  // Request decode
  logic        misaligned;
  logic        reqAccept;
  logic        reqError;
  logic [1:0]  reqLane;
  logic        reqHalfHi;
  logic [3:0]  byteWen;
  logic [3:0]  reqWen;
  logic [31:0] reqRepl;

  // Load return path
  logic [7:0]  laneByte [4];
  logic [1:0]  rdLane;
  logic        rdHalfHi;
  logic [7:0]  rdByte;
  logic [15:0] rdHalf;
  logic [31:0] loadExt;
  logic        timeoutHit;

  always_comb begin
    case (req_size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = req_addr[0];
      2'd2:    misaligned = |req_addr[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  assign reqAccept = (stateReg == S_IDLE) && req_valid && !misaligned;
  assign reqError  = (stateReg == S_IDLE) && req_valid &&  misaligned;

  // Big-endian mirrors the lane index: 3 - x is simply ~x on two bits.
  assign reqLane   = BIG_ENDIAN ? ~req_addr[1:0] : req_addr[1:0];
  assign reqHalfHi = BIG_ENDIAN ? ~req_addr[1]   : req_addr[1];
  assign rdLane    = BIG_ENDIAN ? ~addrReg[1:0]  : addrReg[1:0];
  assign rdHalfHi  = BIG_ENDIAN ? ~addrReg[1]    : addrReg[1];

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_lane
    assign byteWen[gi]  = (reqLane == 2'(gi));
    assign laneByte[gi] = mem_rdata[8*gi +: 8];
  end

  always_comb begin
    reqWen  = 4'b0000;
    reqRepl = req_wdata;
    case (req_size)
      2'd0: begin
        reqWen  = byteWen;
        reqRepl = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        reqWen  = reqHalfHi ? 4'b1100 : 4'b0011;
        reqRepl = {2{req_wdata[15:0]}};
      end
      2'd2:    reqWen = 4'b1111;
      default: reqWen = 4'b0000;
    endcase
  end

  assign rdByte = laneByte[rdLane];
  assign rdHalf = rdHalfHi ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    case (sizeReg)
      2'd0:    loadExt = {{24{signedReg & rdByte[7]}}, rdByte};
      2'd1:    loadExt = {{16{signedReg & rdHalf[15]}}, rdHalf};
      default: loadExt = mem_rdata;
    endcase
  end

  // waitCnt holds the number of WAIT cycles already completed, so the
  // TIMEOUT-th WAIT cycle is the last one; an ack in that cycle still wins.
  assign timeoutHit = (TIMEOUT != 0) && (waitCnt == CNT_W'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg <= S_IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  // Next-state logic
  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      S_IDLE: begin
        if (reqAccept) begin
          stateNext = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_ack) begin
          stateNext = S_DONE;
        end else if (timeoutHit) begin
          stateNext = S_IDLE;
        end
      end
      S_DONE:  stateNext = S_IDLE;
      default: stateNext = S_IDLE;
    endcase
  end

  // Output logic. Bus outputs are forced to zero outside WAIT so a stale
  // transaction never shows on the bus.
  always_comb begin
    stall       = 1'b0;
    mem_en      = 1'b0;
    mem_wen     = 4'b0000;
    mem_addr    = '0;
    mem_wdata   = 32'd0;
    rdata_valid = 1'b0;
    case (stateReg)
      S_IDLE: stall = reqAccept;
      S_WAIT: begin
        stall     = 1'b1;
        mem_en    = 1'b1;
        mem_wen   = wenReg;
        mem_addr  = {addrReg[ADDR_W-1:2], 2'b00};
        mem_wdata = wdataReg;
      end
      S_DONE:  rdata_valid = !weReg;
      default: stall = 1'b0;
    endcase
  end

  // Request context, wait counter, load data and error reporting
  always_ff @(posedge clk) begin
    if (rst) begin
      addrReg    <= '0;
      sizeReg    <= 2'd0;
      signedReg  <= 1'b0;
      weReg      <= 1'b0;
      wenReg     <= 4'b0000;
      wdataReg   <= 32'd0;
      waitCnt    <= '0;
      rdataReg   <= 32'd0;
      adelReg    <= 1'b0;
      adesReg    <= 1'b0;
      busErrReg  <= 1'b0;
      badAddrReg <= '0;
    end else begin
      adelReg   <= 1'b0;
      adesReg   <= 1'b0;
      busErrReg <= 1'b0;

      if (reqError) begin
        adelReg    <= !req_we;
        adesReg    <= req_we;
        badAddrReg <= req_addr;
      end

      if (reqAccept) begin
        addrReg   <= req_addr;
        sizeReg   <= req_size;
        signedReg <= req_signed;
        weReg     <= req_we;
        wenReg    <= req_we ? reqWen : 4'b0000;
        wdataReg  <= reqRepl;
        waitCnt   <= '0;
      end

      if (stateReg == S_WAIT) begin
        waitCnt <= waitCnt + 1'b1;
        if (mem_ack) begin
          if (!weReg) begin
            rdataReg <= loadExt;
          end
        end else if (timeoutHit) begin
          busErrReg  <= 1'b1;
          badAddrReg <= addrReg;
        end
      end
    end
  end

  assign rdata    = rdataReg;
  assign adel     = adelReg;
  assign ades     = adesReg;
  assign bus_err  = busErrReg;
  assign bad_addr = badAddrReg;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Testbench for lsu_mem_port. Two instances (little- and big-endian, same
// TIMEOUT) receive identical stimulus. A driver issues requests and pushes
// expected bus transfers, load results and error pulses into queues; a
// monitor pops and compares whenever a DUT presents one of those events.
module tb_lsu_mem_port;

  localparam int AW = 16;
  localparam int TO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          reqValid;
  logic          reqWe;
  logic [1:0]    reqSize;
  logic          reqSigned;
  logic [AW-1:0] reqAddr;
  logic [31:0]   reqWdata;
  logic [31:0]   memRdata;
  logic          memAck;

  logic [1:0]          stall;
  logic [1:0]          rdataValid;
  logic [1:0]          adel;
  logic [1:0]          ades;
  logic [1:0]          busErr;
  logic [1:0]          memEn;
  logic [1:0][31:0]    rdata;
  logic [1:0][31:0]    memWdata;
  logic [1:0][AW-1:0]  badAddr;
  logic [1:0][AW-1:0]  memAddr;
  logic [1:0][3:0]     memWen;

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_dut
    lsu_mem_port #(.ADDR_W(AW), .BIG_ENDIAN(gi == 1), .TIMEOUT(TO)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (reqValid),
      .req_we     (reqWe),
      .req_size   (reqSize),
      .req_signed (reqSigned),
      .req_addr   (reqAddr),
      .req_wdata  (reqWdata),
      .stall      (stall[gi]),
      .rdata      (rdata[gi]),
      .rdata_valid(rdataValid[gi]),
      .adel       (adel[gi]),
      .ades       (ades[gi]),
      .bus_err    (busErr[gi]),
      .bad_addr   (badAddr[gi]),
      .mem_en     (memEn[gi]),
      .mem_wen    (memWen[gi]),
      .mem_addr   (memAddr[gi]),
      .mem_wdata  (memWdata[gi]),
      .mem_rdata  (memRdata),
      .mem_ack    (memAck)
    );
  end

  typedef struct {
    logic [AW-1:0]   addr;
    logic [1:0][3:0] wen;
    logic [31:0]     wdata;
    bit              isStore;
    int              len;
  } busExp_t;

  typedef struct {
    logic [1:0][31:0] data;
  } loadExp_t;

  typedef struct {
    logic [2:0]    kind;   // {bus_err, ades, adel}
    logic [AW-1:0] addr;
  } errExp_t;

  busExp_t  busQ[$];
  loadExp_t loadQ[$];
  errExp_t  errQ[$];

  int total = 0;
  int bad   = 0;
  int txnNum = 0;
  bit monOn = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    total++;
    bad++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  // ---------------- reference model ----------------
  // Memory byte at word offset off sits in lane off (LE) or 3-off (BE).
  function automatic int laneOf(input bit be, input int off);
    return be ? 3 - off : off;
  endfunction

  function automatic bit misalignedOf(input int size, input logic [AW-1:0] addr);
    if (size == 3) return 1'b1;
    return (int'(addr[1:0]) % (1 << size)) != 0;
  endfunction

  function automatic logic [3:0] strobesOf(input bit be, input int size, input logic [AW-1:0] addr);
    logic [3:0] s = 4'b0000;
    for (int k = 0; k < (1 << size); k++) s[laneOf(be, int'(addr[1:0]) + k)] = 1'b1;
    return s;
  endfunction

  // Assemble the accessed bytes in memory order, most significant first for
  // big-endian, then extend.
  function automatic logic [31:0] loadOf(input bit be, input int size, input bit sgn,
                                         input logic [AW-1:0] addr, input logic [31:0] word);
    int n = 1 << size;
    logic [63:0] v = 64'd0;
    logic [7:0] b;
    for (int k = 0; k < n; k++) begin
      b = word[8*laneOf(be, int'(addr[1:0]) + k) +: 8];
      if (be) v = (v << 8) | 64'(b);
      else    v = v | (64'(b) << (8*k));
    end
    if (sgn && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
    return v[31:0];
  endfunction

  function automatic logic [31:0] replOf(input int size, input logic [31:0] d);
    if (size == 0) return 32'h01010101 * {24'd0, d[7:0]};
    if (size == 1) return 32'h00010001 * {16'd0, d[15:0]};
    return d;
  endfunction

  // ---------------- driver ----------------
  // ackDelay = number of WAIT cycles before mem_ack; >= TO means never.
  task automatic doReq(input bit we, input int size, input bit sgn, input logic [AW-1:0] addr,
                       input logic [31:0] wdata, input logic [31:0] word, input int ackDelay);
    bit mis;
    bit acked;
    busExp_t bx;
    loadExp_t lx;
    errExp_t ex;
    mis = misalignedOf(size, addr);
    acked = ackDelay < TO;
    txnNum++;
    $display("txn %0d: %s size=%0d signed=%0d addr=%h wdata=%h word=%h delay=%0d",
             txnNum, we ? "store" : "load", size, sgn, addr, wdata, word, ackDelay);
    reqValid  = 1'b1;
    reqWe     = we;
    reqSize   = 2'(size);
    reqSigned = sgn;
    reqAddr   = addr;
    reqWdata  = wdata;
    if (mis) begin
      ex.kind = we ? 3'b010 : 3'b001;
      ex.addr = addr;
      errQ.push_back(ex);
    end else begin
      bx.addr    = {addr[AW-1:2], 2'b00};
      bx.wdata   = replOf(size, wdata);
      bx.isStore = we;
      bx.len     = acked ? ackDelay + 1 : TO;
      for (int i = 0; i < 2; i++) bx.wen[i] = we ? strobesOf(i == 1, size, addr) : 4'b0000;
      busQ.push_back(bx);
      if (acked && !we) begin
        for (int i = 0; i < 2; i++) lx.data[i] = loadOf(i == 1, size, sgn, addr, word);
        loadQ.push_back(lx);
      end
      if (!acked) begin
        ex.kind = 3'b100;
        ex.addr = addr;
        errQ.push_back(ex);
      end
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) check("stall_on_request", 32'(stall[i]), mis ? 32'd0 : 32'd1);
    @(posedge clk); #1;
    reqValid = 1'b0;
    if (!mis) begin
      for (int k = 0; k < TO; k++) begin
        memAck   = (k == ackDelay);
        memRdata = (k == ackDelay) ? word : $urandom;
        @(posedge clk); #1;
        memAck = 1'b0;
        if (k == ackDelay) break;
      end
      if (acked) begin
        // DONE cycle: a request here belongs to the same instruction
        reqValid = 1'($urandom_range(0, 1));
        reqSize  = 2'($urandom_range(0, 3));
        reqAddr  = AW'($urandom);
        reqWe    = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        reqValid = 1'b0;
      end
    end
  endtask

  task automatic checkAllZero(input string tag);
    for (int i = 0; i < 2; i++) begin
      check({tag, "_stall"},     32'(stall[i]), 32'd0);
      check({tag, "_rdata"},     rdata[i], 32'd0);
      check({tag, "_rvalid"},    32'(rdataValid[i]), 32'd0);
      check({tag, "_adel"},      32'(adel[i]), 32'd0);
      check({tag, "_ades"},      32'(ades[i]), 32'd0);
      check({tag, "_bus_err"},   32'(busErr[i]), 32'd0);
      check({tag, "_bad_addr"},  32'(badAddr[i]), 32'd0);
      check({tag, "_mem_en"},    32'(memEn[i]), 32'd0);
      check({tag, "_mem_wen"},   32'(memWen[i]), 32'd0);
      check({tag, "_mem_addr"},  32'(memAddr[i]), 32'd0);
      check({tag, "_mem_wdata"}, memWdata[i], 32'd0);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    busExp_t cur;
    loadExp_t lx;
    errExp_t ex;
    logic [1:0] memEnPrev;
    int memRun[2];
    int stallRun[2];
    logic [2:0] ev[2];
    cur.addr = '0; cur.wen = '0; cur.wdata = 32'd0; cur.isStore = 1'b0; cur.len = 0;
    memEnPrev = 2'b00;
    memRun = '{0, 0};
    stallRun = '{0, 0};
    forever begin
      @(negedge clk);
      if (monOn) begin
        if (memEn[0] && !memEnPrev[0]) begin
          if (busQ.size() == 0) unexpected("bus_access");
          else cur = busQ.pop_front();
        end
        for (int i = 0; i < 2; i++) begin
          if (memEnPrev[i] && !memEn[i]) begin
            check("mem_en_cycles", 32'(memRun[i]), 32'(cur.len));
            check("stall_cycles", 32'(stallRun[i]), 32'(cur.len + 1));
            memRun[i]   = 0;
            stallRun[i] = stall[i] ? 1 : 0;
          end else begin
            memRun[i]   = memEn[i] ? memRun[i] + 1 : 0;
            stallRun[i] = stall[i] ? stallRun[i] + 1 : 0;
          end
          if (memEn[i]) begin
            check("mem_addr", 32'(memAddr[i]), 32'(cur.addr));
            check("mem_wen", 32'(memWen[i]), 32'(cur.wen[i]));
            if (cur.isStore) check("mem_wdata", memWdata[i], cur.wdata);
          end
        end
        memEnPrev = memEn;

        if (|rdataValid) begin
          if (loadQ.size() == 0) unexpected("rdata_valid");
          else begin
            lx = loadQ.pop_front();
            for (int i = 0; i < 2; i++) begin
              check("rdata_valid", 32'(rdataValid[i]), 32'd1);
              check("rdata", rdata[i], lx.data[i]);
            end
          end
        end

        for (int i = 0; i < 2; i++) ev[i] = {busErr[i], ades[i], adel[i]};
        if (|(ev[0] | ev[1])) begin
          if (errQ.size() == 0) unexpected("error_pulse");
          else begin
            ex = errQ.pop_front();
            for (int i = 0; i < 2; i++) begin
              check("error_kind", 32'(ev[i]), 32'(ex.kind));
              check("bad_addr", 32'(badAddr[i]), 32'(ex.addr));
            end
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    busExp_t bx;
    logic [AW-1:0] addr;
    logic [1:0] mask;
    int size;
    int delay;
    rst = 1'b1; reqValid = 1'b0; reqWe = 1'b0; reqSize = 2'd0; reqSigned = 1'b0;
    reqAddr = '0; reqWdata = 32'd0; memRdata = 32'd0; memAck = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkAllZero("reset");
    monOn = 1'b1;
    @(posedge clk); #1;

    // directed cases
    doReq(1'b1, 2, 1'b0, 16'h0100, 32'hDEADBEEF, 32'd0, 0);
    doReq(1'b0, 0, 1'b1, 16'h0103, 32'd0, 32'h80FF1234, 0);
    doReq(1'b0, 0, 1'b0, 16'h0103, 32'd0, 32'h80FF1234, 1);
    doReq(1'b1, 1, 1'b0, 16'h0102, 32'h0000ABCD, 32'd0, 2);
    doReq(1'b0, 1, 1'b1, 16'h0206, 32'd0, 32'h8001F00F, 0);
    doReq(1'b0, 2, 1'b0, 16'h0101, 32'd0, 32'd0, 0);
    doReq(1'b1, 1, 1'b0, 16'h0203, 32'h12345678, 32'd0, 0);
    doReq(1'b0, 3, 1'b0, 16'h0300, 32'd0, 32'd0, 0);
    doReq(1'b1, 3, 1'b0, 16'h0304, 32'h0, 32'd0, 0);
    doReq(1'b0, 2, 1'b1, 16'h0040, 32'd0, 32'h11223344, TO);
    doReq(1'b1, 2, 1'b0, 16'h0044, 32'hCAFEF00D, 32'd0, TO - 1);
    doReq(1'b0, 1, 1'b1, 16'h0046, 32'd0, 32'hFFEE8899, TO - 1);

    // reset while a load is waiting on the bus
    txnNum++;
    $display("txn %0d: load size=2 addr=0080 interrupted by reset", txnNum);
    bx.addr = 16'h0080; bx.wen = '0; bx.wdata = 32'd0; bx.isStore = 1'b0; bx.len = 3;
    busQ.push_back(bx);
    reqValid = 1'b1; reqWe = 1'b0; reqSize = 2'd2; reqSigned = 1'b0; reqAddr = 16'h0080;
    @(posedge clk); #1 reqValid = 1'b0; memRdata = $urandom;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checkAllZero("after_reset");
    @(posedge clk); #1 memAck = 1'b1; memRdata = 32'h80808080;
    @(negedge clk);
    for (int i = 0; i < 2; i++) check("stray_ack_rvalid", 32'(rdataValid[i]), 32'd0);
    @(posedge clk); #1 memAck = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) check("stray_ack_rvalid", 32'(rdataValid[i]), 32'd0);
    @(posedge clk); #1;
    doReq(1'b0, 0, 1'b1, 16'h0081, 32'd0, 32'h00C3A500, 1);

    // randomized traffic
    for (int t = 0; t < 150; t++) begin
      size = $urandom_range(0, 3);
      addr = AW'($urandom);
      if (size < 3 && $urandom_range(0, 3) != 0) begin
        mask = 2'((1 << size) - 1);
        addr[1:0] = addr[1:0] & ~mask;
      end
      delay = ($urandom_range(0, 9) == 0) ? TO + $urandom_range(0, 1) : $urandom_range(0, TO - 1);
      doReq(1'($urandom_range(0, 1)), size, 1'($urandom_range(0, 1)), addr, $urandom, $urandom, delay);
    end

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("bus_queue_drained", 32'(busQ.size()), 32'd0);
    check("load_queue_drained", 32'(loadQ.size()), 32'd0);
    check("err_queue_drained", 32'(errQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Parametrised load/store unit between the MEM pipeline stage and the data-memory bus.
- Functions:
  - checks request size and alignment;
  - generates byte-lane write strobes and replicated write data;
  - runs a wait-state handshake with memory and stalls the pipeline while a transaction is in flight;
  - returns sign- or zero-extended load data.
- Extends the fixed 4-bit byte-write scheme with:
  - variable address width;
  - a selectable endianness mode;
  - bus timeout detection.

Parameters:
- ADDR_W, 32, byte address width (data width fixed at 32).
- BIG_ENDIAN, 0, 0 = little-endian lane mapping, 1 = big-endian lane mapping.
- TIMEOUT, 16, maximum WAIT cycles without mem_ack before bus error; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  MEM-stage load/store request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved
- req_signed  in  1  sign-extend load data
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data (right-justified)
- stall  out  1  hold the pipeline
- rdata  out  32  extended load data
- rdata_valid  out  1  load complete (1-cycle pulse)
- adel  out  1  load address/size error (1-cycle pulse)
- ades  out  1  store address/size error (1-cycle pulse)
- bus_err  out  1  timeout (1-cycle pulse)
- bad_addr  out  ADDR_W  faulting address, held until the next error
- mem_en  out  1  bus request
- mem_wen  out  4  byte write strobes (0 for loads)
- mem_addr  out  ADDR_W  word-aligned address (low 2 bits 0)
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  raw read word
- mem_ack  in  1  transfer done; sampled only while mem_en = 1

Behaviour:
- Reset: all outputs are 0; state is IDLE; the timeout counter is cleared.
  - Reset mid-transaction drops mem_en at the reset edge.
  - A late mem_ack arriving in IDLE is ignored.
- States:
  - IDLE: a request is accepted only when req_valid = 1.
    - A misaligned or reserved-size request produces a 1-cycle pulse: adel for a load, ades for a store. bad_addr takes req_addr, stall stays 0, no bus access, state stays IDLE.
    - An aligned request registers addr/size/signed/we/strobes/data, asserts stall combinationally in the same cycle, and moves to WAIT.
    - Misaligned means: half with addr[0] = 1; word with addr[1:0] != 0; size = 3.
  - WAIT: mem_en = 1 and all mem_* outputs are held stable. stall = 1.
    - On mem_ack: capture and extend mem_rdata, go to DONE.
    - If the counter reaches TIMEOUT (TIMEOUT > 0) with no ack: bus_err pulses, bad_addr is set, mem_en drops, return to IDLE. stall = 1 in that cycle.
    - An ack arriving in the same cycle as the timeout wins.
  - DONE: stall = 0, mem_en = 0. rdata_valid = 1 for loads only. Return to IDLE. req_valid is ignored in DONE because it is the same instruction.
- Minimum transaction: accept at T, mem_en at T+1, ack at T+1, DONE at T+2. stall is high during T and T+1.
- Byte lanes for little-endian (lane = addr[1:0]):
  - byte: wen = 1 << lane;
  - half: wen = 0011 or 1100;
  - word: wen = 1111.
- For BIG_ENDIAN = 1, the byte lane is 3 - addr[1:0] and the half lanes are swapped.
- mem_wdata replicates the data:
  - byte: {4{b}};
  - half: {2{h}};
  - word: unchanged.
- Load extension: the selected lane is extracted, then sign-extended if req_signed = 1, otherwise zero-extended. rdata holds its value until the next load completes.

Test Plan:
- LE word store: addr 0x100, data 0xDEADBEEF, ack delay 0 → mem_wen = 1111, mem_addr = 0x100, mem_wdata = 0xDEADBEEF, stall high for 2 cycles, no rdata_valid.
- Signed byte load: addr 0x103, mem_rdata = 0x80FF1234 → rdata = 0xFFFFFF80 with one rdata_valid pulse.
  - Same request with req_signed = 0 → rdata = 0x00000080.
  - BIG_ENDIAN = 1, same addr → rdata = 0x00000034.
- Half store: addr 0x102, data 0x0000ABCD → mem_wen = 1100, mem_wdata = 0xABCDABCD.
  - BIG_ENDIAN = 1 → mem_wen = 0011.
- Misaligned: word load at 0x101 → adel pulses, bad_addr = 0x101, mem_en stays 0, stall stays 0.
  - Half store at 0x203 → ades pulses.
  - size = 3 → adel/ades pulses.
- Timeout: TIMEOUT = 4, no ack → mem_en high for 4 cycles, bus_err pulses, bad_addr = request addr, back to IDLE.
  - Ack in the 4th cycle → normal completion, no bus_err.
- Reset in WAIT: assert rst with mem_en = 1 → next cycle all outputs 0.
  - A subsequent stray mem_ack produces no rdata_valid.
  - A new request afterwards completes normally.
